// File: rtl/line_buffer_3x3.sv
// Two-line raster buffer feeding a 3x3 kernel: one top/mid/bot column per beat plus window-centre
// edge flags. Optional macro LB_SOF_SYNC_EN adds sof_in for start-of-frame resynchronisation.
module line_buffer_3x3 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              valid_in,
`ifdef LB_SOF_SYNC_EN
  input  logic              sof_in,
`endif
  output logic              in_ready,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] mid,
  output logic [DATA_W-1:0] bot,
  output logic              valid_out,
  output logic              top_edge,
  output logic              bot_edge,
  output logic              left_edge,
  output logic              right_edge,
  output logic              win_skip
);

  localparam int unsigned XW = $clog2(IMG_W + 1);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned AW = $clog2(IMG_W);
  localparam logic [XW-1:0] XOne  = XW'(1);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [XW-1:0] XPad  = XW'(IMG_W);
  localparam logic [YW-1:0] YOne  = YW'(1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  typedef enum logic [1:0] {StFill, StStream, StPad, StFlush} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              flush_pad_q, flush_pad_d;
  logic [XW-1:0]     beat_c_q, beat_c_d;
  logic [YW-1:0]     beat_y_q, beat_y_d;
  logic [DATA_W-1:0] top_d, mid_d, bot_d;
  logic              beat;
  logic              accept;
  logic              sof;
  logic [AW-1:0]     addr, wr_addr;

  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];

  assign in_ready = (state_q == StFill) || (state_q == StStream);
  assign accept   = valid_in && in_ready;
  assign addr     = x_q[AW-1:0];

`ifdef LB_SOF_SYNC_EN
  // A start-of-frame on the pixel already expected at (0,0) is a no-op.
  assign sof = accept && sof_in && !((state_q == StFill) && (x_q == '0));
`else
  assign sof = 1'b0;
`endif

  assign wr_addr = sof ? '0 : addr;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    flush_pad_d = 1'b0;
    beat        = 1'b0;
    top_d       = '0;
    mid_d       = '0;
    bot_d       = '0;
    beat_c_d    = x_q;
    beat_y_d    = y_q - YOne;

    unique case (state_q)
      StFill: begin
        // Trailing zero pad of the previous frame's flush row.
        if (flush_pad_q) begin
          beat     = 1'b1;
          beat_c_d = XPad;
          beat_y_d = YLast;
        end
        if (accept) begin
          if (x_q == XLast) begin
            x_d     = '0;
            y_d     = YOne;
            state_d = StStream;
          end else begin
            x_d = x_q + XOne;
          end
        end
      end
      StStream: begin
        if (accept) begin
          beat  = 1'b1;
          top_d = (y_q == YOne) ? '0 : lb_a[addr];
          mid_d = lb_b[addr];
          bot_d = pixel_in;
          if (x_q == XLast) begin
            x_d     = '0;
            state_d = StPad;
          end else begin
            x_d = x_q + XOne;
          end
        end
      end
      StPad: begin
        beat     = 1'b1;
        beat_c_d = XPad;
        if (y_q == YLast) begin
          state_d = StFlush;
        end else begin
          y_d     = y_q + YOne;
          state_d = StStream;
        end
      end
      StFlush: begin
        beat     = 1'b1;
        top_d    = lb_a[addr];
        mid_d    = lb_b[addr];
        beat_y_d = y_q;
        if (x_q == XLast) begin
          x_d         = '0;
          y_d         = '0;
          flush_pad_d = 1'b1;
          state_d     = StFill;
        end else begin
          x_d = x_q + XOne;
        end
      end
      default: state_d = StFill;
    endcase

    if (sof) begin
      state_d     = StFill;
      x_d         = XOne;
      y_d         = '0;
      beat        = 1'b0;
      flush_pad_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[wr_addr] <= lb_b[wr_addr];
      lb_b[wr_addr] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      x_q         <= '0;
      y_q         <= '0;
      flush_pad_q <= 1'b0;
      beat_c_q    <= '0;
      beat_y_q    <= '0;
      valid_out   <= 1'b0;
      top         <= '0;
      mid         <= '0;
      bot         <= '0;
      top_edge    <= 1'b0;
      bot_edge    <= 1'b0;
      left_edge   <= 1'b0;
      right_edge  <= 1'b0;
      win_skip    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      flush_pad_q <= flush_pad_d;
      valid_out   <= beat;
      if (beat) begin
        top      <= top_d;
        mid      <= mid_d;
        bot      <= bot_d;
        beat_c_q <= beat_c_d;
        beat_y_q <= beat_y_d;
      end
      // Flags describe the centre (c-1, y) of the column the sink consumes at this edge.
      if (valid_out) begin
        win_skip   <= (beat_c_q == '0);
        left_edge  <= (beat_c_q == XOne);
        right_edge <= (beat_c_q == XPad);
        top_edge   <= (beat_c_q != '0) && (beat_y_q == '0);
        bot_edge   <= (beat_c_q != '0) && (beat_y_q == YLast);
      end
    end
  end

endmodule
